// File: rtl/dg_merge_arb.sv
// N-channel round-robin merge node with a DEPTH-entry output FIFO tagging each word with its source channel.
// Optional per-channel grant counters are built when DG_MERGE_CNT_EN is defined.
module dg_merge_arb #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          in_valid,
  input  logic [NUM_CH*DATA_W-1:0]   in_data,
  output logic [NUM_CH-1:0]          in_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(NUM_CH)-1:0]  out_ch,
  input  logic                       out_ready
`ifdef DG_MERGE_CNT_EN
  ,
  input  logic                       cnt_clr,
  output logic [NUM_CH*CNT_W-1:0]    grant_cnt
`endif
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam int AW   = $clog2(DEPTH);
  localparam int PW   = AW + 1;

  logic [CH_W-1:0]   r_lg;
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_count;
  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [CH_W-1:0]   r_mem_ch   [DEPTH];

  logic              w_en;
  logic              w_gnt_any;
  logic [CH_W-1:0]   w_gnt_idx;
  logic [NUM_CH-1:0] w_gnt;
  logic              w_push;
  logic              w_pop;

  // Grant is masked during reset so in_ready reads zero even though count is zero.
  always_comb begin
    w_en      = rst_n && (r_count < PW'(DEPTH));
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_gnt     = '0;
    for (int unsigned k = 1; k <= unsigned'(NUM_CH); k++) begin
      int unsigned idx;
      idx = 32'(r_lg) + k;
      if (idx >= unsigned'(NUM_CH)) idx = idx - unsigned'(NUM_CH);
      if (!w_gnt_any && in_valid[idx]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = CH_W'(idx);
      end
    end
    if (w_en && w_gnt_any) w_gnt[w_gnt_idx] = 1'b1;
  end

  assign in_ready  = w_gnt;
  assign w_push    = w_en && w_gnt_any;
  assign w_pop     = (r_count != '0) && out_ready;
  assign out_valid = (r_count != '0);
  assign out_data  = r_mem_data[r_rd_ptr[AW-1:0]];
  assign out_ch    = r_mem_ch[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lg     <= CH_W'(NUM_CH - 1);
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < unsigned'(DEPTH); i++) begin
        r_mem_data[i] <= '0;
        r_mem_ch[i]   <= '0;
      end
    end else begin
      if (w_push) begin
        r_lg                        <= w_gnt_idx;
        r_mem_data[r_wr_ptr[AW-1:0]] <= in_data[w_gnt_idx*DATA_W +: DATA_W];
        r_mem_ch[r_wr_ptr[AW-1:0]]   <= w_gnt_idx;
        r_wr_ptr                    <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef DG_MERGE_CNT_EN
  logic [CNT_W-1:0] r_cnt [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt[g] <= '0;
      end else if (cnt_clr) begin
        r_cnt[g] <= '0;
      end else if (w_gnt[g] && (r_cnt[g] != '1)) begin
        r_cnt[g] <= r_cnt[g] + 1'b1;
      end
    end
    assign grant_cnt[g*CNT_W +: CNT_W] = r_cnt[g];
  end
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_dg_merge_arb.sv
// Randomised scoreboard bench for dg_merge_arb: a queue-based reference model predicts grants and
// the ordered output stream; a separate monitor pops expected words when the DUT presents them.
module tb_dg_merge_arb;
  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CH_W   = 2;
`ifdef DG_MERGE_CNT_EN
  localparam int CNT_W  = 2;
`endif

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic [CH_W-1:0]          out_ch;
  logic                     out_ready;
`ifdef DG_MERGE_CNT_EN
  logic                     cnt_clr;
  logic [NUM_CH*CNT_W-1:0]  grant_cnt;
  int                       gc_m [NUM_CH];
  int                       clr_pct = 0;
`endif

  always #5 clk = ~clk;

  dg_merge_arb #(
    .NUM_CH(NUM_CH),
    .DATA_W(DATA_W),
`ifdef DG_MERGE_CNT_EN
    .CNT_W (CNT_W),
`endif
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ch   (out_ch),
`ifdef DG_MERGE_CNT_EN
    .cnt_clr  (cnt_clr),
    .grant_cnt(grant_cnt),
`endif
    .out_ready(out_ready)
  );

  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t              sb[$];
  int                checks = 0;
  int                errors = 0;
  int                cnt_m = 0;
  int                lg_m = NUM_CH - 1;
  int                valid_pct = 0;
  int                ready_pct = 0;
  logic [NUM_CH-1:0] ch_en = '0;
  bit                fixed_data = 1'b0;
  logic [7:0]        seq [NUM_CH];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arbitration: first valid channel after the last grant, only while the model FIFO has room.
  function automatic int exp_grant();
    if (cnt_m >= DEPTH) return -1;
    for (int k = 1; k <= NUM_CH; k++) begin
      int c;
      c = (lg_m + k) % NUM_CH;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    sb.delete();
    cnt_m = 0;
    lg_m  = NUM_CH - 1;
`ifdef DG_MERGE_CNT_EN
    for (int c = 0; c < NUM_CH; c++) gc_m[c] = 0;
`endif
  endtask

  task automatic drive_inputs(input int g);
    for (int c = 0; c < NUM_CH; c++) begin
      if (g == c) in_valid[c] = 1'b0;
      if (!in_valid[c] && ch_en[c] && ($urandom_range(99) < valid_pct)) begin
        in_valid[c] = 1'b1;
        in_data[c*DATA_W +: DATA_W] = fixed_data ? DATA_W'(8'h10 + c) : seq[c];
        seq[c] = seq[c] + 8'd1;
      end
    end
    out_ready = ($urandom_range(99) < ready_pct);
`ifdef DG_MERGE_CNT_EN
    cnt_clr = ($urandom_range(99) < clr_pct);
`endif
  endtask

  task automatic cycle();
    int                g;
    bit                pop;
    logic [NUM_CH-1:0] exp_rdy;
    @(negedge clk);
    g = exp_grant();
    exp_rdy = (g >= 0) ? (NUM_CH'(1) << g) : '0;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
`ifdef DG_MERGE_CNT_EN
    for (int c = 0; c < NUM_CH; c++)
      check("grant_cnt", 32'(grant_cnt[c*CNT_W +: CNT_W]), gc_m[c]);
`endif
    pop = (cnt_m != 0) && out_ready;
    @(posedge clk);
    if (g >= 0) begin
      sb.push_back({CH_W'(g), in_data[g*DATA_W +: DATA_W]});
      lg_m = g;
    end
    cnt_m = cnt_m + int'(g >= 0) - int'(pop);
`ifdef DG_MERGE_CNT_EN
    for (int c = 0; c < NUM_CH; c++) begin
      if (cnt_clr) gc_m[c] = 0;
      else if (g == c && gc_m[c] < (1 << CNT_W) - 1) gc_m[c]++;
    end
`endif
    #1;
    drive_inputs(g);
  endtask

  always @(negedge clk) begin
    check("out_valid", 32'(out_valid), 32'(cnt_m != 0));
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        ent_t e;
        e = sb.pop_front();
        check("out_ch", 32'(out_ch), 32'(e.ch));
        check("out_data", 32'(out_data), 32'(e.d));
      end
    end
  end

  initial begin
    int n;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef DG_MERGE_CNT_EN
    cnt_clr   = 1'b0;
`endif
    for (int c = 0; c < NUM_CH; c++) seq[c] = 8'd1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    in_valid = '1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_ch", 32'(out_ch), 32'd0);
    in_valid = '0;

    // Round robin with all channels valid and fixed payload 0x10+i.
    rst_n = 1'b1;
    fixed_data = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      in_valid[c] = 1'b1;
      in_data[c*DATA_W +: DATA_W] = DATA_W'(8'h10 + c);
    end
    out_ready = 1'b1;
    ch_en = '1; valid_pct = 100; ready_pct = 100;
    repeat (16) cycle();

    // Drain, then stream channel 2 into a stalled output until full.
    fixed_data = 1'b0;
    ch_en = '0;
    repeat (12) cycle();
    seq[2] = 8'd1;
    ch_en = 4'b0100; ready_pct = 0;
    repeat (8) cycle();
    ready_pct = 100;
    repeat (12) cycle();

    // Random traffic across pointer wraps.
    ch_en = '1; valid_pct = 60; ready_pct = 50;
`ifdef DG_MERGE_CNT_EN
    clr_pct = 8;
`endif
    repeat (300) cycle();
`ifdef DG_MERGE_CNT_EN
    clr_pct = 0;
`endif

    // Reset mid-stream at count 3.
    ch_en = '0; ready_pct = 100;
    repeat (20) cycle();
    ch_en = 4'b0100; ready_pct = 0; valid_pct = 100;
    n = 0;
    while (cnt_m != 3 && n < 20) begin
      cycle();
      n++;
    end
    check("reach_count3", 32'(cnt_m), 32'd3);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    in_valid  = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_valid = '1;
    ch_en = '1; valid_pct = 100; ready_pct = 100;
    repeat (12) cycle();

    ch_en = '0;
    repeat (12) cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/dg_merge_arb.md
# dg_merge_arb

Parametrised N-channel merge node for the datagraph hierarchy: arbitrates NUM_CH valid/ready input streams round-robin onto one output stream, tagging each word with its source channel. It buffers accepted words in a DEPTH-entry FIFO. It is the generalised replacement for fixed-arity hand-wired fan-in: instances compose by name into merge trees, with one node's output feeding a parent node's input.

## Interface
- NUM_CH, default 4: number of input channels, 2..16.
- DATA_W, default 8: payload width per channel, ≥1.
- DEPTH, default 4: output FIFO entries, power of two, ≥2.
- CNT_W, default 16: grant counter width. Used only with DG_MERGE_CNT_EN.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  NUM_CH  per-channel valid.
- in_data  in  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- in_ready  out  NUM_CH  per-channel ready, one-hot or zero.
- out_valid  out  1  FIFO head valid.
- out_data  out  DATA_W  FIFO head payload.
- out_ch  out  $clog2(NUM_CH)  source channel of the head word.
- out_ready  in  1  downstream accepts the head.
- cnt_clr  in  1  synchronous clear of grant counters. Present only with DG_MERGE_CNT_EN.
- grant_cnt  out  NUM_CH*CNT_W  per-channel accepted-word counts. Present only with DG_MERGE_CNT_EN.

## Operation
- Transfer rules: input i transfers when in_valid[i] && in_ready[i]; the output transfers when out_valid && out_ready.
- Arbitration is combinational from in_valid, the FIFO count and the last-grant pointer lg.
  - It is enabled only when count < DEPTH. There is no full-with-pop bypass, so out_ready has no combinational path to in_ready.
  - When enabled, the grant goes to the first channel with in_valid set, searching circularly from lg+1.
  - in_ready is the one-hot grant; it is all zero when disabled or when no channel has in_valid set.
- On a transfer, lg takes the granted index. Otherwise lg holds.
- FIFO: write pointer, read pointer and count, each log2(DEPTH)+1 bits.
  - Push writes {channel, data} at wr_ptr.
  - Pop advances rd_ptr.
  - Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave count unchanged.
- out_valid = (count != 0). out_data and out_ch come from the head entry.
- Once out_valid is high, out_data and out_ch stay stable until the pop.
- Upstream must keep in_valid and in_data stable until transfer. The block does not check this.

## Timing
- Reset (rst_n low, asynchronous):
  - count = 0, pointers = 0, lg = NUM_CH-1, so channel 0 has first priority.
  - out_valid = 0, in_ready = 0.
  - out_data and out_ch are 0; FIFO storage is cleared.
  - grant_cnt is 0.
- Reset release takes effect on the first rising edge with rst_n high.
- Latency: a word accepted at edge k drives out_valid high after edge k, provided the FIFO was empty.
- Throughput: one word per cycle sustained while out_ready is held high.
- FIFO full (count = DEPTH): in_ready = 0 in that cycle. A pop at that edge re-enables the grant in the next cycle, giving one bubble per full-stall.
- FIFO empty with out_ready high: no pop; out_ready is ignored.
- Reset asserted mid-transfer: the in-flight word is discarded and all state returns to reset values immediately.

## Configuration
- Macro: DG_MERGE_CNT_EN.
- Defined:
  - Adds cnt_clr and grant_cnt.
  - grant_cnt[i] increments on each input-i transfer and saturates at 2^CNT_W-1.
  - cnt_clr has priority over an increment in the same cycle; the counter reads 0 after that edge.
- Undefined: the counter ports and logic are absent; all other behaviour is identical.

## Test plan
- Reset with NUM_CH=4, DEPTH=4: out_valid=0, in_ready=0000, lg=3. Raise in_valid=1111 after reset -> first grant goes to channel 0.
- Round-robin fairness: all four valid, out_ready=1, data = 0x10+i -> out_ch sequence 0,1,2,3,0,... Each out_data matches its out_ch. One word per cycle after the first.
- Full backpressure: out_ready=0 with channel 2 streaming 0x01..0x06 -> 4 words accepted, then in_ready=0. Raise out_ready -> outputs 0x01..0x06 in order, with one bubble per full-stall.
- Pointer wrap: 20 words through DEPTH=4 with random out_ready -> no loss, duplication or reordering per channel.
- Reset mid-stream: assert rst_n low with count=3 -> out_valid drops the same cycle. After release the FIFO is empty and lg=3.
- DG_MERGE_CNT_EN with CNT_W=2: 5 grants to channel 1 -> grant_cnt[1]=3 (saturated). cnt_clr together with a channel-1 grant -> grant_cnt[1]=0.
